// File: rtl/line_matrix_pkg.sv
// rtl/line_matrix_pkg.sv - shared line-matrix constants and sequencer state encoding
package line_matrix_pkg;

   localparam int LM_N_IN  = 8;
   localparam int LM_N_OUT = 9;
   localparam int LM_SEL_W = 4;

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4
   } lm_state_t;

   function automatic int lm_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lm_phase_timer.sv
// rtl/lm_phase_timer.sv - loadable down-counter; o_tc flags the last cycle of a loaded phase
module lm_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tc   = (r_cnt == W'(1));
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/line_matrix_cfg_seq.sv
// rtl/line_matrix_cfg_seq.sv - sequencer driving line_matrix strobe, reset and select lines
module line_matrix_cfg_seq
   import line_matrix_pkg::*;
#(
   parameter int N_IN       = LM_N_IN,
   parameter int N_OUT      = LM_N_OUT,
   parameter int SEL_W      = LM_SEL_W,
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [SEL_W-1:0] cfg_in_sel,
   input  logic [SEL_W-1:0] cfg_out_sel,
   input  logic             clr_req,
   output logic             lm_clk,
   output logic             lm_rstn,
   output logic [SEL_W-1:0] lm_in_sel,
   output logic [SEL_W-1:0] lm_out_sel,
   output logic             busy,
   output logic             err_range,
   output logic [CNT_W-1:0] routes_done
);

   localparam int TW = $clog2(lm_max(CLK_DIV, RST_CYCLES) + 1);

   lm_state_t        r_state, w_state_nxt;
   logic             r_clr_pend, w_pend_nxt;
   logic             r_cfg_ready, r_busy, r_err, r_lm_clk, r_lm_rstn;
   logic             w_err_nxt;
   logic [SEL_W-1:0] r_in_sel, r_out_sel, w_in_nxt, w_out_nxt;
   logic [CNT_W-1:0] r_done, w_done_nxt;
   logic             w_load, w_tc, w_zero, w_in_ok, w_out_ok;
   logic [TW-1:0]    w_load_val;

   assign w_in_ok  = (32'(cfg_in_sel) < N_IN);
   assign w_out_ok = (32'(cfg_out_sel) < N_OUT);

   lm_phase_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tc       (w_tc),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = TW'(CLK_DIV);
      w_pend_nxt  = r_clr_pend;
      w_err_nxt   = 1'b0;
      w_in_nxt    = r_in_sel;
      w_out_nxt   = r_out_sel;
      w_done_nxt  = r_done;
      if (clr_req && (r_state == ST_SETUP || r_state == ST_STROBE || r_state == ST_HOLD))
         w_pend_nxt = 1'b1;
      case (r_state)
         // A zero count in CLEAR only occurs straight after rst, so it arms the boot clear.
         ST_CLEAR: begin
            if (clr_req || w_zero) begin
               w_load     = 1'b1;
               w_load_val = TW'(RST_CYCLES);
            end else if (w_tc) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_load      = 1'b1;
               w_load_val  = TW'(RST_CYCLES);
            end else if (cfg_valid && r_cfg_ready) begin
               if (w_in_ok && w_out_ok) begin
                  w_state_nxt = ST_SETUP;
                  w_load      = 1'b1;
                  w_in_nxt    = cfg_in_sel;
                  w_out_nxt   = cfg_out_sel;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (w_tc) begin
               w_state_nxt = ST_STROBE;
               w_load      = 1'b1;
            end
         end
         ST_STROBE: begin
            if (w_tc) begin
               w_state_nxt = ST_HOLD;
               w_load      = 1'b1;
               w_done_nxt  = r_done + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (w_tc) begin
               if (w_pend_nxt) begin
                  w_state_nxt = ST_CLEAR;
                  w_load      = 1'b1;
                  w_load_val  = TW'(RST_CYCLES);
                  w_pend_nxt  = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_CLEAR;
         r_clr_pend  <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b1;
         r_err       <= 1'b0;
         r_lm_clk    <= 1'b0;
         r_lm_rstn   <= 1'b0;
         r_in_sel    <= '0;
         r_out_sel   <= '0;
         r_done      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_pend  <= w_pend_nxt;
         r_cfg_ready <= (w_state_nxt == ST_IDLE);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_err       <= w_err_nxt;
         r_lm_clk    <= (w_state_nxt == ST_STROBE);
         r_lm_rstn   <= (w_state_nxt != ST_CLEAR);
         r_in_sel    <= w_in_nxt;
         r_out_sel   <= w_out_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign cfg_ready   = r_cfg_ready;
   assign busy        = r_busy;
   assign err_range   = r_err;
   assign lm_clk      = r_lm_clk;
   assign lm_rstn     = r_lm_rstn;
   assign lm_in_sel   = r_in_sel;
   assign lm_out_sel  = r_out_sel;
   assign routes_done = r_done;

endmodule

// File: tb/tb_line_matrix_cfg_seq.sv
// tb/tb_line_matrix_cfg_seq.sv - directed bench for line_matrix_cfg_seq (CLK_DIV=4, RST_CYCLES=8)
module tb_line_matrix_cfg_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid, cfg_ready, clr_req;
   logic [3:0] cfg_in_sel, cfg_out_sel, lm_in_sel, lm_out_sel;
   logic       lm_clk, lm_rstn, busy, err_range;
   logic [7:0] routes_done;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_done = 8'd0;

   line_matrix_cfg_seq #(
      .N_IN(8), .N_OUT(9), .SEL_W(4), .CLK_DIV(4), .RST_CYCLES(8), .CNT_W(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_in_sel  (cfg_in_sel),
      .cfg_out_sel (cfg_out_sel),
      .clr_req     (clr_req),
      .lm_clk      (lm_clk),
      .lm_rstn     (lm_rstn),
      .lm_in_sel   (lm_in_sel),
      .lm_out_sel  (lm_out_sel),
      .busy        (busy),
      .err_range   (err_range),
      .routes_done (routes_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; cfg_valid = 1'b0; clr_req = 1'b0; cfg_in_sel = '0; cfg_out_sel = '0;
      repeat (2) @(negedge clk);
      n_vec++; if ({lm_clk, lm_rstn, cfg_ready, busy, err_range} !== 5'b00010) begin n_err++; $display("FAIL reset_flags got %b exp 00010", {lm_clk, lm_rstn, cfg_ready, busy, err_range}); end
      n_vec++; if ({lm_in_sel, lm_out_sel, routes_done} !== 16'h0) begin n_err++; $display("FAIL reset_values got %h exp 0000", {lm_in_sel, lm_out_sel, routes_done}); end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         n_vec++; if (lm_rstn !== 1'b0 || cfg_ready !== 1'b0) begin n_err++; $display("FAIL boot_clear k=%0d lm_rstn=%b ready=%b exp 0 0", k, lm_rstn, cfg_ready); end
      end
      tick;
      n_vec++; if ({lm_rstn, cfg_ready, busy, lm_clk, err_range} !== 5'b11000) begin n_err++; $display("FAIL boot_done got %b exp 11000", {lm_rstn, cfg_ready, busy, lm_clk, err_range}); end
   endtask

   task automatic test_route;
      cfg_valid = 1'b1; cfg_in_sel = 4'd5; cfg_out_sel = 4'd2;
      tick;
      cfg_valid = 1'b0;
      n_vec++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_err++; $display("FAIL route_accept busy=%b ready=%b exp 1 0", busy, cfg_ready); end
      for (int k = 1; k <= 12; k++) begin
         tick;
         n_vec++; if (lm_clk !== (k >= 4 && k <= 7)) begin n_err++; $display("FAIL route_lm_clk k=%0d got %b", k, lm_clk); end
         n_vec++; if (routes_done !== exp_done + 8'(k >= 8)) begin n_err++; $display("FAIL route_done k=%0d got %0d", k, routes_done); end
         n_vec++; if (cfg_ready !== (k == 12)) begin n_err++; $display("FAIL route_ready k=%0d got %b", k, cfg_ready); end
         if (k == 1) begin
            n_vec++; if (lm_in_sel !== 4'd5 || lm_out_sel !== 4'd2) begin n_err++; $display("FAIL route_sel got %0d/%0d exp 5/2", lm_in_sel, lm_out_sel); end
         end
      end
      exp_done = exp_done + 8'd1;
   endtask

   task automatic test_back_to_back;
      cfg_valid = 1'b1; cfg_in_sel = 4'd1; cfg_out_sel = 4'd8;
      tick;
      for (int k = 1; k <= 25; k++) begin
         tick;
         n_vec++; if (lm_clk !== ((k >= 4 && k <= 7) || (k >= 17 && k <= 20))) begin n_err++; $display("FAIL b2b_lm_clk k=%0d got %b", k, lm_clk); end
         n_vec++; if (cfg_ready !== (k == 12 || k == 25)) begin n_err++; $display("FAIL b2b_ready k=%0d got %b", k, cfg_ready); end
         n_vec++; if (routes_done !== exp_done + 8'(k >= 8) + 8'(k >= 21)) begin n_err++; $display("FAIL b2b_done k=%0d got %0d", k, routes_done); end
         if (k == 1) begin
            n_vec++; if (lm_in_sel !== 4'd1 || lm_out_sel !== 4'd8) begin n_err++; $display("FAIL b2b_sel1 got %0d/%0d exp 1/8", lm_in_sel, lm_out_sel); end
         end
         if (k == 13) begin
            n_vec++; if (lm_in_sel !== 4'd7 || lm_out_sel !== 4'd0) begin n_err++; $display("FAIL b2b_sel2 got %0d/%0d exp 7/0", lm_in_sel, lm_out_sel); end
         end
         if (k == 12) begin cfg_in_sel = 4'd7; cfg_out_sel = 4'd0; end
         if (k == 13) cfg_valid = 1'b0;
      end
      exp_done = exp_done + 8'd2;
   endtask

   task automatic test_range;
      cfg_valid = 1'b1; cfg_in_sel = 4'd3; cfg_out_sel = 4'd9;
      tick;
      cfg_valid = 1'b0;
      n_vec++; if ({err_range, cfg_ready, busy} !== 3'b110) begin n_err++; $display("FAIL range_out_err got %b exp 110", {err_range, cfg_ready, busy}); end
      n_vec++; if (lm_in_sel !== 4'd7 || lm_out_sel !== 4'd0) begin n_err++; $display("FAIL range_sel_kept got %0d/%0d exp 7/0", lm_in_sel, lm_out_sel); end
      tick;
      n_vec++; if (err_range !== 1'b0) begin n_err++; $display("FAIL range_pulse_width got %b exp 0", err_range); end
      cfg_valid = 1'b1; cfg_in_sel = 4'd8; cfg_out_sel = 4'd0;
      tick;
      cfg_valid = 1'b0;
      n_vec++; if (err_range !== 1'b1) begin n_err++; $display("FAIL range_in_err got %b exp 1", err_range); end
      for (int k = 1; k <= 6; k++) begin
         tick;
         n_vec++; if (lm_clk !== 1'b0 || busy !== 1'b0 || err_range !== 1'b0 || routes_done !== exp_done) begin n_err++; $display("FAIL range_idle k=%0d clk=%b busy=%b err=%b done=%0d", k, lm_clk, busy, err_range, routes_done); end
      end
   endtask

   task automatic test_clear;
      clr_req = 1'b1; cfg_valid = 1'b1; cfg_in_sel = 4'd2; cfg_out_sel = 4'd3;
      tick;
      clr_req = 1'b0; cfg_valid = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) tick;
         n_vec++; if (lm_rstn !== (k == 8) || cfg_ready !== (k == 8) || lm_clk !== 1'b0) begin n_err++; $display("FAIL clear_prio k=%0d rstn=%b ready=%b clk=%b", k, lm_rstn, cfg_ready, lm_clk); end
      end
      n_vec++; if (routes_done !== exp_done) begin n_err++; $display("FAIL clear_no_route got %0d exp %0d", routes_done, exp_done); end
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      tick;
      tick;
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         n_vec++; if (lm_rstn !== (k == 8)) begin n_err++; $display("FAIL clear_restart k=%0d rstn=%b", k, lm_rstn); end
      end
   endtask

   task automatic test_clr_in_strobe;
      cfg_valid = 1'b1; cfg_in_sel = 4'd4; cfg_out_sel = 4'd5;
      tick;
      cfg_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         n_vec++; if (lm_clk !== (k >= 4 && k <= 7)) begin n_err++; $display("FAIL pend_lm_clk k=%0d got %b", k, lm_clk); end
         n_vec++; if (lm_rstn !== !(k >= 12 && k <= 19)) begin n_err++; $display("FAIL pend_lm_rstn k=%0d got %b", k, lm_rstn); end
         n_vec++; if (cfg_ready !== (k == 20)) begin n_err++; $display("FAIL pend_ready k=%0d got %b", k, cfg_ready); end
         n_vec++; if (routes_done !== exp_done + 8'(k >= 8)) begin n_err++; $display("FAIL pend_done k=%0d got %0d", k, routes_done); end
         clr_req = (k == 5 || k == 9);
      end
      exp_done = exp_done + 8'd1;
   endtask

   task automatic test_async_reset;
      cfg_valid = 1'b1; cfg_in_sel = 4'd6; cfg_out_sel = 4'd1;
      tick;
      cfg_valid = 1'b0;
      repeat (5) tick;
      n_vec++; if (lm_clk !== 1'b1) begin n_err++; $display("FAIL arst_pre_strobe got %b exp 1", lm_clk); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if ({lm_clk, lm_rstn, cfg_ready, busy} !== 4'b0001 || routes_done !== 8'd0) begin n_err++; $display("FAIL arst_async flags=%b done=%0d exp 0001 0", {lm_clk, lm_rstn, cfg_ready, busy}, routes_done); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick;
         n_vec++; if (lm_rstn !== (k == 9) || cfg_ready !== (k == 9) || lm_clk !== 1'b0) begin n_err++; $display("FAIL arst_reboot k=%0d rstn=%b ready=%b clk=%b", k, lm_rstn, cfg_ready, lm_clk); end
      end
   endtask

   initial begin
      test_reset;
      test_route;
      test_back_to_back;
      test_range;
      test_clear;
      test_clr_in_strobe;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
